// File: rtl/ads1292_pkg.sv
// Purpose: shared frame layout, field positions and helpers for the ADS1292 frame path.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package ads1292_pkg;

  localparam int STATUS_MSB = 71;
  localparam int LOFF_MSB   = 67;
  localparam int LOFF_LSB   = 63;
  localparam int CH1_MSB    = 47;
  localparam int CH2_MSB    = 23;
  localparam int SAMPLE_W   = 24;
  localparam int FRAME_W    = 72;
  localparam int LOFF_W     = LOFF_MSB - LOFF_LSB + 1;

  localparam logic [3:0] HEADER = 4'hC;

  // Bit offset of the status word inside the full frame.
  localparam int STATUS_LSB = CH1_MSB + 1;

  typedef struct packed {
    logic [SAMPLE_W-1:0] status;
    logic [SAMPLE_W-1:0] ch1;
    logic [SAMPLE_W-1:0] ch2;
  } frame_t;

  // A frame is trusted only when the fixed 4-bit sync nibble is present.
  function automatic logic header_ok(input frame_t f);
    return f.status[STATUS_MSB-STATUS_LSB -: 4] == HEADER;
  endfunction

  // LOFF_STAT bits, re-based from frame positions into the status word.
  function automatic logic [LOFF_W-1:0] lead_off_bits(input frame_t f);
    return f.status[LOFF_MSB-STATUS_LSB : LOFF_LSB-STATUS_LSB];
  endfunction

  // Channel 2 occupies the bottom of the frame.
  function automatic logic [SAMPLE_W-1:0] ch2_bits(input frame_t f);
    return f.ch2[CH2_MSB:0];
  endfunction

endpackage

// File: rtl/khu_sync_fifo.sv
// Purpose: single-clock circular FIFO with wrap-bit pointers and an occupancy count.
// Latency: write at the push edge, visible on rd_data the next cycle; read data is mem[rd_ptr].
// Backpressure: push is ignored when full unless a pop happens in the same cycle; pop ignored when empty.
module khu_sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
  assign level   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // A pop frees the head slot this cycle, so a push into a full FIFO is still legal then.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage is deliberately left unreset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Pointer update; clear collapses both pointers back to slot 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/ads1292_frame_buffer.sv
// Purpose: validate RDATAC frames, extract one channel into a FIFO, track lead-off and error counts.
// Latency: frame edge at clock N -> sample/level/lead-off visible in cycle N+1; ack at N -> next head at N+1.
// Backpressure: consumer acks to pop; frames arriving while full are dropped and counted.
module ads1292_frame_buffer
  import ads1292_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int CH_SEL = 1,
  parameter int CNT_W  = 16
) (
  input  logic                     i_CLK,
  input  logic                     i_RSTN,
  input  logic [FRAME_W-1:0]       i_ADS1292_DATA_OUT,
  input  logic                     i_ADS1292_DATA_VALID,
  input  logic                     i_CLEAR,
  output logic [SAMPLE_W-1:0]      o_SAMPLE_DATA,
  output logic                     o_SAMPLE_VALID,
  input  logic                     i_SAMPLE_ACK,
  output logic [LOFF_W-1:0]        o_LEAD_OFF,
  output logic [$clog2(DEPTH):0]   o_FIFO_LEVEL,
  output logic [CNT_W-1:0]         o_OVERFLOW_CNT,
  output logic [CNT_W-1:0]         o_HEADER_ERR_CNT
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  frame_t              frame;
  logic                valid_d;
  logic                frame_edge;
  logic                take;
  logic                hdr_good;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                push;
  logic                drop;
  logic                hdr_bad;
  logic [SAMPLE_W-1:0] sample;

  assign frame      = frame_t'(i_ADS1292_DATA_OUT);
  assign frame_edge = i_ADS1292_DATA_VALID & ~valid_d;
  assign hdr_good   = header_ok(frame);
  assign sample     = (CH_SEL == 0) ? frame.ch1 : ch2_bits(frame);

  // Clear overrides everything, including a frame landing on the same edge.
  assign take    = frame_edge & ~i_CLEAR;
  assign pop     = i_SAMPLE_ACK & ~fifo_empty & ~i_CLEAR;
  assign push    = take & hdr_good & (~fifo_full | pop);
  assign drop    = take & hdr_good & fifo_full & ~pop;
  assign hdr_bad = take & ~hdr_good;

  assign o_SAMPLE_VALID = ~fifo_empty;

  // Delayed flag for rising-edge detect; resets high so a flag held across reset is not a frame.
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) valid_d <= 1'b1;
    else         valid_d <= i_ADS1292_DATA_VALID;
  end

  // Lead-off status follows the most recent frame with a good header.
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN)                   o_LEAD_OFF <= '0;
    else if (i_CLEAR)              o_LEAD_OFF <= '0;
    else if (take && hdr_good)     o_LEAD_OFF <= lead_off_bits(frame);
  end

  // Saturating error counters for dropped-on-full and bad-header frames.
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      o_OVERFLOW_CNT   <= '0;
      o_HEADER_ERR_CNT <= '0;
    end else if (i_CLEAR) begin
      o_OVERFLOW_CNT   <= '0;
      o_HEADER_ERR_CNT <= '0;
    end else begin
      if (drop && o_OVERFLOW_CNT != '1)      o_OVERFLOW_CNT   <= o_OVERFLOW_CNT + CNT_ONE;
      if (hdr_bad && o_HEADER_ERR_CNT != '1) o_HEADER_ERR_CNT <= o_HEADER_ERR_CNT + CNT_ONE;
    end
  end

  khu_sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (i_CLK),
    .rst_n     (i_RSTN),
    .clear     (i_CLEAR),
    .push      (push),
    .push_data (sample),
    .pop       (pop),
    .rd_data   (o_SAMPLE_DATA),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (o_FIFO_LEVEL)
  );

endmodule

// File: tb/tb_ads1292_frame_buffer.sv
// Purpose: directed bench for ads1292_frame_buffer with a queue-based expected-sample scoreboard.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: ack is driven explicitly per step to exercise full/empty corners.
module tb_ads1292_frame_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [71:0] frame_in;
  logic        dv;
  logic        clr;
  logic        ack;

  logic [23:0] s_data, s_data0;
  logic        s_valid, s_valid0;
  logic [4:0]  loff, loff0;
  logic [4:0]  lvl, lvl0;
  logic [15:0] ovf, ovf0;
  logic [15:0] herr, herr0;

  int checks = 0;
  int errors = 0;

  logic [23:0] sb[$];
  int          exp_hdr;
  int          exp_ovf;
  logic [4:0]  exp_loff;

  always #5 clk = ~clk;

  ads1292_frame_buffer #(.DEPTH(16), .CH_SEL(1), .CNT_W(16)) dut (
    .i_CLK (clk), .i_RSTN (rst_n),
    .i_ADS1292_DATA_OUT (frame_in), .i_ADS1292_DATA_VALID (dv),
    .i_CLEAR (clr),
    .o_SAMPLE_DATA (s_data), .o_SAMPLE_VALID (s_valid), .i_SAMPLE_ACK (ack),
    .o_LEAD_OFF (loff), .o_FIFO_LEVEL (lvl),
    .o_OVERFLOW_CNT (ovf), .o_HEADER_ERR_CNT (herr)
  );

  ads1292_frame_buffer #(.DEPTH(16), .CH_SEL(0), .CNT_W(16)) dut0 (
    .i_CLK (clk), .i_RSTN (rst_n),
    .i_ADS1292_DATA_OUT (frame_in), .i_ADS1292_DATA_VALID (dv),
    .i_CLEAR (clr),
    .o_SAMPLE_DATA (s_data0), .o_SAMPLE_VALID (s_valid0), .i_SAMPLE_ACK (ack),
    .o_LEAD_OFF (loff0), .o_FIFO_LEVEL (lvl0),
    .o_OVERFLOW_CNT (ovf0), .o_HEADER_ERR_CNT (herr0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected effect of one frame edge on the scoreboard and counters.
  task automatic model_frame(input logic [71:0] f);
    if (f[71:68] == 4'hC) begin
      exp_loff = f[67:63];
      if (sb.size() < 16) sb.push_back(f[23:0]);
      else                exp_ovf++;
    end else begin
      exp_hdr++;
    end
  endtask

  task automatic model_reset();
    sb.delete();
    exp_hdr  = 0;
    exp_ovf  = 0;
    exp_loff = '0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ":valid"}, 32'(s_valid), 32'(sb.size() != 0));
    chk({tag, ":level"}, 32'(lvl), 32'(sb.size()));
    chk({tag, ":hdr_cnt"}, 32'(herr), 32'(exp_hdr));
    chk({tag, ":ovf_cnt"}, 32'(ovf), 32'(exp_ovf));
    chk({tag, ":lead_off"}, 32'(loff), 32'(exp_loff));
    if (sb.size() != 0) chk({tag, ":head"}, 32'(s_data), 32'(sb[0]));
  endtask

  // One frame: flag high for a cycle then low for a cycle (minimum edge spacing).
  task automatic send(input logic [71:0] f);
    frame_in = f;
    dv = 1'b1;
    model_frame(f);
    @(negedge clk);
    dv = 1'b0;
    @(negedge clk);
  endtask

  // Hold ack for n cycles, checking each head against the scoreboard before it pops.
  task automatic drain(input int n);
    ack = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk("drain_head", 32'(s_data), 32'(sb[0]));
      void'(sb.pop_front());
      @(negedge clk);
    end
    ack = 1'b0;
  endtask

  initial begin
    model_reset();
    rst_n    = 1'b0;
    dv       = 1'b1;
    frame_in = '0;
    clr      = 1'b0;
    ack      = 1'b0;

    // Release reset with the flag already high: no frame may be taken.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_state("reset_flag_high");

    // First real frame; outputs checked in the cycle right after the edge.
    dv = 1'b0;
    @(negedge clk);
    frame_in = 72'hC00000_000000_123456;
    dv = 1'b1;
    model_frame(frame_in);
    @(negedge clk);
    check_state("first_push");
    chk("first_data", 32'(s_data), 32'h123456);
    dv = 1'b0;
    @(negedge clk);

    // Bad header with lead-off bits set: counted, not stored, lead-off untouched.
    send(72'h8F8000_000000_000777);
    check_state("bad_hdr");
    chk("bad_hdr_loff", 32'(loff), 32'h0);

    send(72'hC80000_000000_000002);
    check_state("loff_update");
    chk("loff_value", 32'(loff), 32'h10);

    drain(2);
    check_state("drained_two");

    // Overfill: 18 frames into 16 slots.
    for (int i = 1; i <= 18; i++) send({24'hC00000, 24'h000000, 24'(i)});
    check_state("overfill");
    chk("overfill_ovf", 32'(ovf), 32'd2);
    chk("overfill_lvl", 32'(lvl), 32'd16);

    drain(16);
    check_state("drain16_empty");

    // Refill to full, then push and pop on the same edge.
    for (int i = 101; i <= 116; i++) send({24'hC00000, 24'h000000, 24'(i)});
    check_state("refill");
    frame_in = {24'hC00000, 24'h000000, 24'd117};
    dv  = 1'b1;
    ack = 1'b1;
    void'(sb.pop_front());
    model_frame(frame_in);
    @(negedge clk);
    dv  = 1'b0;
    ack = 1'b0;
    check_state("full_push_pop");
    chk("full_push_pop_head", 32'(s_data), 32'd102);
    @(negedge clk);

    // Bring level to 5, then clear on the same edge as a good frame.
    drain(11);
    check_state("level5");
    frame_in = 72'hC80000_000000_0000AA;
    dv  = 1'b1;
    clr = 1'b1;
    model_reset();
    @(negedge clk);
    dv  = 1'b0;
    clr = 1'b0;
    check_state("clear_with_edge");
    @(negedge clk);

    // Channel selection on both instances.
    send(72'hC00000_ABCDEF_000001);
    check_state("ch2_select");
    chk("ch1_select_data", 32'(s_data0), 32'hABCDEF);
    chk("ch1_select_valid", 32'(s_valid0), 32'd1);

    // Make all state nonzero, then reset asynchronously between clock edges.
    send(72'h800000_000000_000009);
    send(72'hC80000_000000_000003);
    check_state("pre_async_rst");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_state("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_state("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ads1292_frame_buffer.md
# ads1292_frame_buffer

Sits between `ads1292_controller` and `ads1292_filter`. It accepts the 72-bit RDATAC frame that the controller flags with a rising `o_ADS1292_DATA_VALID`. It checks the ADS1292 status header, extracts one channel's 24-bit sample and publishes lead-off status. Samples are queued in a small FIFO and drained to the filter over a valid/ack handshake, so a slow filter cannot lose frames silently. Overflow and header errors are counted.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `CH_SEL`, 1: channel extracted; 0 = CH1 [47:24], 1 = CH2 [23:0].
- `CNT_W`, 16: width of the error counters.

Ports:
- `i_CLK`  in  1  system clock (50 MHz domain, same as the controller).
- `i_RSTN`  in  1  reset; asynchronous, active-low.
- `i_ADS1292_DATA_OUT`  in  72  frame from the controller. Layout: [71:48] status, [47:24] CH1, [23:0] CH2.
- `i_ADS1292_DATA_VALID`  in  1  frame-ready flag; only its rising edge is meaningful.
- `i_CLEAR`  in  1  synchronous flush of the FIFO, the counters and the lead-off register.
- `o_SAMPLE_DATA`  out  24  head-of-FIFO sample, two's complement.
- `o_SAMPLE_VALID`  out  1  FIFO not empty.
- `i_SAMPLE_ACK`  in  1  consumer pops the head entry.
- `o_LEAD_OFF`  out  5  LOFF_STAT from the last good frame.
- `o_FIFO_LEVEL`  out  log2(DEPTH)+1  number of entries currently held.
- `o_OVERFLOW_CNT`  out  CNT_W  good frames dropped because the FIFO was full; saturating.
- `o_HEADER_ERR_CNT`  out  CNT_W  frames rejected for a bad header; saturating.

## Operation
**Edge detect**
- `valid_d` <= `i_ADS1292_DATA_VALID` every cycle.
- An edge is a cycle where `i_ADS1292_DATA_VALID & !valid_d`.
- `valid_d` resets to 1, so a flag already high at reset release is not a frame.
- `i_CLEAR` does not touch `valid_d`.

**Frame check on an edge**
- Good header: status[23:20] == 4'hC, i.e. bits [71:68].
- Bad header: the frame is dropped, `o_HEADER_ERR_CNT` +1, and `o_LEAD_OFF` is left unchanged.
- Good header: `o_LEAD_OFF` <= bits [67:63].
  - If the FIFO is not full, the selected channel is pushed.
  - If the FIFO is full, the sample is dropped and `o_OVERFLOW_CNT` +1.
- Both counters saturate at all-ones and never wrap.

**FIFO and pop**
- Circular buffer with read/write pointers that carry one extra wrap bit.
  - Full: pointers differ only in the MSB.
  - Empty: pointers are equal.
- `o_SAMPLE_DATA` is driven directly from `mem[rd_ptr]`.
- `o_SAMPLE_VALID` = !empty.
- A pop happens on any cycle with `i_SAMPLE_ACK & o_SAMPLE_VALID`. An ack while empty is ignored.
- A held ack pops one entry per cycle.

**Simultaneous events**
- Push and pop in the same cycle:
  - When full: both are performed, level stays at DEPTH, no overflow is counted.
  - When empty: only the push happens, because valid is low that cycle.
- `i_CLEAR` together with an edge: clear wins, the frame is discarded and no counter is incremented.

**Clear**
- Pointers, level, both counters and `o_LEAD_OFF` go to 0.
- Memory contents are not cleared.

## Timing
- Reset values:
  - `o_SAMPLE_VALID` = 0, `o_FIFO_LEVEL` = 0, `o_LEAD_OFF` = 0, both counters = 0.
  - `o_SAMPLE_DATA` = `mem[0]`; its value is don't-care while valid is low.
- Reset is asynchronous at any time. A frame mid-capture is lost and pointers go to 0.
- Push latency:
  - Edge at clock edge N → entry written at N.
  - `o_SAMPLE_VALID`, `o_FIFO_LEVEL` and `o_LEAD_OFF` update after edge N and are visible in cycle N+1.
- Pop: an ack sampled at edge N → the next head (or valid=0) is visible in cycle N+1.
- Throughput: one push per rising edge of the flag. The minimum edge spacing is 2 cycles, set by the flag going low and high again.
- Every output is registered or a memory read; no combinational path runs from `i_SAMPLE_ACK` to any output.

## Structure
- Package `ads1292_pkg` holds:
  - the frame-field constants: STATUS_MSB=71, LOFF_MSB=67, LOFF_LSB=63, CH1_MSB=47, CH2_MSB=23;
  - HEADER=4'hC and SAMPLE_W=24;
  - the frame-field typedef.
- Sub-module `khu_sync_fifo`, parameterised by width and depth, with push/pop/full/empty/level.
- The top-level block contains the edge detect, header check, lead-off register and counters.

## Test plan
- Reset is released with the flag held high → no push and level stays 0. Then the flag drops and rises with frame 72'hC00000_000000_123456 → `o_SAMPLE_DATA`=24'h123456, valid=1, level=1 in cycle N+1.
- Send a frame with header 4'h8 → header count =1, no push, `o_LEAD_OFF` unchanged. Next, send a frame with status 24'hC80000 → `o_LEAD_OFF`=5'b10000.
- Send 18 good frames with ack held low → level=16, overflow count =2. Then ack for 16 cycles → samples 1..16 come out in order and valid=0 afterwards.
- With the FIFO full, push and ack in the same cycle → level stays 16, overflow count unchanged, the head advances by one.
- Assert `i_CLEAR` in the same cycle as an edge, with the FIFO at level 5 and both counters nonzero → level, counters and lead-off all 0, and the frame is not stored.
- Set CH_SEL=0, send CH1=24'hABCDEF and CH2=24'h000001 → output is 24'hABCDEF. Assert `i_RSTN` low asynchronously mid-stream → all outputs return to their reset values without waiting for a clock.
